// File: rtl/actuator_pattern_memory_if.sv
// Host strobe bus and playback stream bundle for the actuator pattern memory.
// The master side is the system controller / actuator driver; the slave side is the memory.
interface actuator_pattern_memory_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  memory_enable_n;
  logic                  memory_write_n;
  logic                  memory_read_n;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic [DATA_WIDTH-1:0] memory_data_in;
  logic [DATA_WIDTH-1:0] memory_data_out;
  logic                  access_error;
  logic                  scan_start_n;
  logic [ADDR_WIDTH-1:0] scan_base;
  logic [ADDR_WIDTH-1:0] scan_count;
  logic [DATA_WIDTH-1:0] scan_data;
  logic                  scan_valid;
  logic                  scan_ready;
  logic                  scan_busy;
  logic                  scan_done;

  modport master (
    output memory_enable_n, memory_write_n, memory_read_n, memory_address, memory_data_in,
    output scan_start_n, scan_base, scan_count, scan_ready,
    input  memory_data_out, access_error, scan_data, scan_valid, scan_busy, scan_done
  );

  modport slave (
    input  memory_enable_n, memory_write_n, memory_read_n, memory_address, memory_data_in,
    input  scan_start_n, scan_base, scan_count, scan_ready,
    output memory_data_out, access_error, scan_data, scan_valid, scan_busy, scan_done
  );
endinterface

// File: rtl/actuator_pattern_memory.sv
// Actuator pattern store: edge-qualified host strobe access plus an independent
// valid/ready playback port that streams consecutive words with address wrap.
module actuator_pattern_memory #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic                     clock,
  input logic                     reset_n,
  actuator_pattern_memory_if.slave bus
);

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam int unsigned CntWidth = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StStream, StDone} scan_state_e;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic                  write_prev_q;
  logic                  read_prev_q;
  logic                  write_qual;
  logic                  read_qual;
  logic                  write_fire;
  logic                  read_fire;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  access_error_q;

  scan_state_e           state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] next_ptr;
  logic [CntWidth-1:0]   remaining_q;
  logic [CntWidth-1:0]   start_count;
  logic [DATA_WIDTH-1:0] scan_data_q;
  logic                  scan_valid_q;
  logic                  scan_done_q;

  // Strobe qualification: an access fires only on the inactive-to-active transition.
  always_comb begin
    write_qual  = ~bus.memory_enable_n & ~bus.memory_write_n;
    read_qual   = ~bus.memory_enable_n & ~bus.memory_read_n;
    write_fire  = write_qual & ~write_prev_q;
    read_fire   = read_qual & ~read_prev_q;
    next_ptr    = ptr_q + 1'b1;
    start_count = (bus.scan_count == '0) ? CntWidth'(Depth) : {1'b0, bus.scan_count};
  end

  // Pattern array; never cleared, and not written while reset is asserted.
  always_ff @(posedge clock) begin
    if (reset_n && write_fire) begin
      mem[bus.memory_address] <= bus.memory_data_in;
    end
  end

  // Host read data, strobe history and sticky collision flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      write_prev_q   <= 1'b0;
      read_prev_q    <= 1'b0;
      data_out_q     <= '0;
      access_error_q <= 1'b0;
    end else begin
      write_prev_q <= write_qual;
      read_prev_q  <= read_qual;
      if (write_fire && read_fire) begin
        // Write wins, read is dropped and the output keeps its old value.
        access_error_q <= 1'b1;
      end else if (read_fire) begin
        data_out_q <= mem[bus.memory_address];
      end
    end
  end

  // Playback FSM; array reads see pre-write contents at a colliding edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      remaining_q  <= '0;
      scan_data_q  <= '0;
      scan_valid_q <= 1'b0;
      scan_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!bus.scan_start_n) begin
            ptr_q        <= bus.scan_base;
            remaining_q  <= start_count;
            scan_data_q  <= mem[bus.scan_base];
            scan_valid_q <= 1'b1;
            state_q      <= StStream;
          end
        end
        StStream: begin
          if (scan_valid_q && bus.scan_ready) begin
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == CntWidth'(1)) begin
              scan_valid_q <= 1'b0;
              scan_done_q  <= 1'b1;
              state_q      <= StDone;
            end else begin
              ptr_q       <= next_ptr;
              scan_data_q <= mem[next_ptr];
            end
          end
        end
        StDone: begin
          scan_done_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          scan_valid_q <= 1'b0;
          scan_done_q  <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign bus.memory_data_out = data_out_q;
  assign bus.access_error    = access_error_q;
  assign bus.scan_data       = scan_data_q;
  assign bus.scan_valid      = scan_valid_q;
  assign bus.scan_done       = scan_done_q;
  assign bus.scan_busy       = (state_q != StIdle);

endmodule
